// File: rtl/dma_bus_master.sv
// Single-channel word-copy DMA initiator on the req/gnt/rvalid data bus.
// Optional grant-wait timeout enabled by defining DMA_TIMEOUT_EN.
module dma_bus_master #(
  parameter int LEN_W          = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic [31:0]      cfg_src,
  input  logic [31:0]      cfg_dst,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             irq_clear,
  output logic             busy,
  output logic             done_irq,
  output logic             err,
  output logic             data_req,
  output logic             data_we,
  output logic [3:0]       data_be,
  output logic [31:0]      data_addr,
  output logic [31:0]      data_wdata,
  input  logic             data_gnt,
  input  logic             data_rvalid,
  input  logic [31:0]      data_rdata
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT
  } state_t;

  state_t           state, state_n;
  logic [31:0]      src, src_n;
  logic [31:0]      dst, dst_n;
  logic [31:0]      buffer, buffer_n;
  logic [LEN_W-1:0] count, count_n;
  logic             done_n, err_n;
  logic             req_n, we_n;
  logic [3:0]       be_n;
  logic [31:0]      addr_n, wdata_n;
  logic             err_q;
  logic             unused_low_bits;

  assign unused_low_bits = ^{cfg_src[1:0], cfg_dst[1:0]};

`ifdef DMA_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo, tmo_n;
  assign err = err_q;
`else
  logic unused_err_q;
  assign unused_err_q = err_q;
  assign err = 1'b0;
`endif

  // Next state, datapath and registered-output values.
  always_comb begin
    state_n  = state;
    src_n    = src;
    dst_n    = dst;
    buffer_n = buffer;
    count_n  = count;
    done_n   = done_irq;
    err_n    = err_q;
    req_n    = data_req;
    we_n     = data_we;
    be_n     = data_be;
    addr_n   = data_addr;
    wdata_n  = data_wdata;
`ifdef DMA_TIMEOUT_EN
    tmo_n    = tmo;
`endif
    if (irq_clear) begin
      done_n = 1'b0;
      err_n  = 1'b0;
    end
    unique case (state)
      IDLE: begin
        if (cfg_start) begin
          if (cfg_len != '0) begin
            src_n   = {cfg_src[31:2], 2'b00};
            dst_n   = {cfg_dst[31:2], 2'b00};
            count_n = cfg_len;
            done_n  = 1'b0;
            err_n   = 1'b0;
            state_n = RD_REQ;
            req_n   = 1'b1;
            we_n    = 1'b0;
            be_n    = 4'hF;
            addr_n  = {cfg_src[31:2], 2'b00};
          end else begin
            done_n = 1'b1;
          end
        end
      end
      RD_REQ, WR_REQ: begin
        if (data_gnt) begin
          req_n   = 1'b0;
          state_n = (state == RD_REQ) ? RD_WAIT : WR_WAIT;
        end
`ifdef DMA_TIMEOUT_EN
        else if (tmo == '0) begin
          req_n   = 1'b0;
          err_n   = 1'b1;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          tmo_n = tmo - 1'b1;
        end
`endif
      end
      RD_WAIT: begin
        if (data_rvalid) begin
          buffer_n = data_rdata;
          src_n    = src + 32'd4;
          state_n  = WR_REQ;
          req_n    = 1'b1;
          we_n     = 1'b1;
          be_n     = 4'hF;
          addr_n   = dst;
          wdata_n  = data_rdata;
        end
      end
      WR_WAIT: begin
        if (data_rvalid) begin
          dst_n   = dst + 32'd4;
          count_n = count - 1'b1;
          if (count == LEN_W'(1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = RD_REQ;
            req_n   = 1'b1;
            we_n    = 1'b0;
            be_n    = 4'hF;
            addr_n  = src;
          end
        end
      end
      default: state_n = IDLE;
    endcase
`ifdef DMA_TIMEOUT_EN
    if (state_n != state &&
        (state_n == RD_REQ || state_n == WR_REQ))
      tmo_n = TMO_LOAD;
`endif
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      src        <= '0;
      dst        <= '0;
      buffer     <= '0;
      count      <= '0;
      busy       <= 1'b0;
      done_irq   <= 1'b0;
      err_q      <= 1'b0;
      data_req   <= 1'b0;
      data_we    <= 1'b0;
      data_be    <= '0;
      data_addr  <= '0;
      data_wdata <= '0;
    end else begin
      state      <= state_n;
      src        <= src_n;
      dst        <= dst_n;
      buffer     <= buffer_n;
      count      <= count_n;
      busy       <= (state_n != IDLE);
      done_irq   <= done_n;
      err_q      <= err_n;
      data_req   <= req_n;
      data_we    <= we_n;
      data_be    <= be_n;
      data_addr  <= addr_n;
      data_wdata <= wdata_n;
    end
  end

`ifdef DMA_TIMEOUT_EN
  // Grant-wait counter, reloaded on entry to a request state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo <= '0;
    else     tmo <= tmo_n;
  end
`endif

endmodule

// File: tb/tb_dma_bus_master.sv
// Directed bench for dma_bus_master with a +1/+1 gnt/rvalid responder.
// Define DMA_TIMEOUT_EN to also exercise the grant timeout.
module tb_dma_bus_master;

  localparam logic [31:0] K = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic [31:0] cfg_src = '0;
  logic [31:0] cfg_dst = '0;
  logic [15:0] cfg_len = '0;
  logic        irq_clear = 1'b0;
  logic        busy, done_irq, err;
  logic        data_req, data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata;
  logic        data_gnt, data_rvalid;
  logic [31:0] data_rdata;
  logic        grant_en = 1'b1;
  int          cyc = 0;
  int          n_assert = 0;
  int          n_fail = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;
  txn_t log_q[$];

  dma_bus_master #(.LEN_W(16), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_src(cfg_src),
    .cfg_dst(cfg_dst), .cfg_len(cfg_len),
    .irq_clear(irq_clear),
    .busy(busy), .done_irq(done_irq), .err(err),
    .data_req(data_req), .data_we(data_we),
    .data_be(data_be), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Responder: gnt one cycle after req, rvalid one cycle after gnt.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      data_gnt    <= 1'b0;
      data_rvalid <= 1'b0;
      data_rdata  <= '0;
    end else begin
      data_rvalid <= 1'b0;
      if (data_req && data_gnt) begin
        log_q.push_back({data_we, data_addr, data_wdata});
        data_gnt    <= 1'b0;
        data_rvalid <= 1'b1;
        data_rdata  <= data_we ? 32'h0 : (data_addr ^ K);
      end else begin
        data_gnt <= data_req && grant_en;
      end
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [31:0] s,
                       input logic [31:0] d,
                       input logic [15:0] l);
    cfg_src   = s;
    cfg_dst   = d;
    cfg_len   = l;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while (!done_irq && t < 400) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done"}, 32'(done_irq), 32'd1);
  endtask

  task automatic clear_irq();
    irq_clear = 1'b1;
    @(negedge clk);
    irq_clear = 1'b0;
  endtask

  task automatic check_copy(input string tag,
                            input logic [31:0] s,
                            input logic [31:0] d,
                            input int n);
    logic [31:0] ra, wa;
    check({tag, "_ntxn"}, 32'(log_q.size()), 32'(2 * n));
    for (int i = 0; i < n && 2 * i + 1 < log_q.size(); i++) begin
      ra = s + 32'(4 * i);
      wa = d + 32'(4 * i);
      check($sformatf("%s_rd%0d_we", tag, i),
            32'(log_q[2*i].we), 32'd0);
      check($sformatf("%s_rd%0d_addr", tag, i),
            log_q[2*i].addr, ra);
      check($sformatf("%s_wr%0d_we", tag, i),
            32'(log_q[2*i+1].we), 32'd1);
      check($sformatf("%s_wr%0d_addr", tag, i),
            log_q[2*i+1].addr, wa);
      check($sformatf("%s_wr%0d_data", tag, i),
            log_q[2*i+1].wdata, ra ^ K);
    end
  endtask

  initial begin
    int t, t0, n;
    logic seen;

    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done_irq), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_req", 32'(data_req), 32'd0);
    check("rst_we", 32'(data_we), 32'd0);
    check("rst_be", 32'(data_be), 32'd0);
    check("rst_addr", data_addr, 32'd0);
    check("rst_wdata", data_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic 4-word copy and its latency.
    log_q.delete();
    start(32'h0002_2000, 32'h0000_1000, 16'd4);
    t = 0;
    while (!data_req && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("b_req_first", 32'(data_req), 32'd1);
    check("b_be", 32'(data_be), 32'hF);
    check("b_busy", 32'(busy), 32'd1);
    t0 = cyc;
    wait_done("b");
    check("b_latency", 32'(cyc - t0), 32'd24);
    check("b_busy_end", 32'(busy), 32'd0);
    check_copy("b", 32'h0002_2000, 32'h0000_1000, 4);
    clear_irq();
    check("b_clr", 32'(done_irq), 32'd0);

    // Zero length: immediate completion, no traffic.
    log_q.delete();
    start(32'h0000_8000, 32'h0000_9000, 16'd0);
    check("z_done", 32'(done_irq), 32'd1);
    check("z_busy", 32'(busy), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen = seen | data_req;
      @(negedge clk);
    end
    check("z_noreq", 32'(seen), 32'd0);
    check("z_ntxn", 32'(log_q.size()), 32'd0);

    // Address wrap and low-bit masking; start clears done_irq.
    log_q.delete();
    start(32'hFFFF_FFFF, 32'h0000_3003, 16'd2);
    check("w_clr_on_start", 32'(done_irq), 32'd0);
    check("w_addr0", data_addr, 32'hFFFF_FFFC);
    wait_done("w");
    check_copy("w", 32'hFFFF_FFFC, 32'h0000_3000, 2);
    n = 0;
    foreach (log_q[i]) if (log_q[i].addr[1:0] != 2'b00) n++;
    check("w_aligned", 32'(n), 32'd0);
    clear_irq();

    // Start while busy is ignored.
    log_q.delete();
    start(32'h0000_4000, 32'h0000_5000, 16'd2);
    repeat (3) @(negedge clk);
    start(32'h0000_9000, 32'h0000_A000, 16'd7);
    wait_done("m");
    check_copy("m", 32'h0000_4000, 32'h0000_5000, 2);
    clear_irq();

    // Reset in WR_REQ abandons the copy.
    log_q.delete();
    start(32'h0000_6000, 32'h0000_7000, 16'd3);
    t = 0;
    while (!(data_req && data_we) && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("r_in_wrreq", 32'({data_req, data_we}), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("r_req", 32'(data_req), 32'd0);
    check("r_busy", 32'(busy), 32'd0);
    check("r_done", 32'(done_irq), 32'd0);
    check("r_we", 32'(data_we), 32'd0);
    check("r_addr", data_addr, 32'd0);
    check("r_wdata", data_wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("r_nodone", 32'(done_irq), 32'd0);
    log_q.delete();
    start(32'h0000_0100, 32'h0000_0200, 16'd1);
    wait_done("r2");
    check_copy("r2", 32'h0000_0100, 32'h0000_0200, 1);
    check("r2_err", 32'(err), 32'd0);
    clear_irq();

`ifdef DMA_TIMEOUT_EN
    // Responder never grants: timeout after 8 request cycles.
    grant_en = 1'b0;
    @(negedge clk);
    start(32'h0000_1000, 32'h0000_2000, 16'd2);
    n = 0;
    t = 0;
    while (data_req && t < 50) begin
      n++;
      @(negedge clk);
      t++;
    end
    check("t_req_cycles", 32'(n), 32'd8);
    check("t_err", 32'(err), 32'd1);
    check("t_done", 32'(done_irq), 32'd1);
    check("t_busy", 32'(busy), 32'd0);
    clear_irq();
    check("t_clr_err", 32'(err), 32'd0);
    check("t_clr_done", 32'(done_irq), 32'd0);
    grant_en = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_bus_master.md
Name: dma_bus_master

Overview:
- Single-channel word-copy DMA engine. It is an initiator on the peripheral data bus (req/gnt/rvalid protocol) that the team's peripheral responders implement.
- Reads a block of 32-bit words from a source address and writes them to a destination address, one transaction outstanding at a time.
- Signals completion on a level interrupt meant to be wired into one bit of the interrupt controller's irq_source vector.
- Configured through direct ports driven by the peripheral block's register file.

Parameters:
- LEN_W, 16, width of the word-count input and the internal remaining counter.
- TIMEOUT_CYCLES, 256, grant-wait limit in cycles. Used only when DMA_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset; asynchronous, active-high
- cfg_start  input  1  one-cycle start pulse
- cfg_src  input  32  source byte address; bits [1:0] ignored
- cfg_dst  input  32  destination byte address; bits [1:0] ignored
- cfg_len  input  LEN_W  number of words to copy
- irq_clear  input  1  clears done_irq and err
- busy  output  1  high while a copy is in progress
- done_irq  output  1  completion interrupt, level
- err  output  1  copy aborted on timeout
- data_req  output  1  bus request
- data_we  output  1  1 = write, 0 = read
- data_be  output  4  byte enables
- data_addr  output  32  word-aligned bus address
- data_wdata  output  32  write data
- data_gnt  input  1  grant from responder
- data_rvalid  input  1  response valid, for reads and writes
- data_rdata  input  32  read data

Behaviour:
- Reset (asynchronous, active-high): state IDLE. Outputs busy, done_irq, err, data_req and data_we are 0. data_be, data_addr and data_wdata are 0. Internal src, dst, count and buffer are 0. Asserting reset mid-copy drops data_req immediately and abandons the copy; no completion is signalled.
- All outputs are registered.
- Bus rules:
  - A transaction is accepted at a rising edge where data_req=1 and data_gnt=1. data_req drops on that same edge.
  - data_addr, data_we, data_be and data_wdata are held stable from req assertion until acceptance.
  - Only one transaction is outstanding. No new req is issued until data_rvalid for the previous one.
  - data_rvalid in any state other than RD_WAIT or WR_WAIT is ignored.
  - data_gnt while data_req=0 is ignored.
- States:
  - IDLE: busy=0.
    - cfg_start with cfg_len!=0: latch src={cfg_src[31:2],2'b00}, dst likewise, count=cfg_len; clear done_irq and err; go to RD_REQ.
    - cfg_start with cfg_len==0: set done_irq, no bus traffic, stay IDLE.
  - RD_REQ: data_req=1, data_we=0, data_be=4'hF, data_addr=src. On gnt, go to RD_WAIT.
  - RD_WAIT: on rvalid, buffer<=data_rdata, src<=src+4, go to WR_REQ.
  - WR_REQ: data_req=1, data_we=1, data_be=4'hF, data_addr=dst, data_wdata=buffer. On gnt, go to WR_WAIT.
  - WR_WAIT: on rvalid, dst<=dst+4, count<=count-1.
    - If count==1: go to IDLE, set done_irq.
    - Otherwise: go to RD_REQ.
- busy=1 in every state except IDLE.
- cfg_start while busy is ignored, including changes to cfg_src, cfg_dst and cfg_len.
- Address increment is modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0.
- done_irq and err are sticky. They clear on irq_clear or on an accepted cfg_start. irq_clear and a completion in the same cycle: completion wins, flag set.
- Throughput against the team's responders (gnt one cycle after req, rvalid one cycle after gnt): 3 cycles per read, 3 per write, 6 cycles per word.
- First data_req rises the cycle after cfg_start is sampled.

Optional Feature:
- Macro: DMA_TIMEOUT_EN.
- Defined:
  - A counter runs in RD_REQ and WR_REQ and reloads on each state entry.
  - If TIMEOUT_CYCLES cycles pass without gnt: drop data_req, set err and done_irq, go to IDLE. Remaining words are not copied.
  - The counter does not run in the WAIT states.
- Not defined: the engine waits for gnt indefinitely; err is tied to 0.

Test Plan:
- src=0x2_2000, dst=0x1000, len=4, responder gnt/rvalid at +1/+1:
  - 4 reads from 0x22000..0x2200C and 4 writes to 0x1000..0x100C, each carrying the read data.
  - done_irq rises 24 cycles after the first req; busy then falls.
- len=0: done_irq set the cycle after start; data_req never asserts.
- src=0xFFFF_FFFC, len=2, src low bits=2'b11: addresses 0xFFFF_FFFC then 0x0000_0000; no misaligned addr driven.
- cfg_start pulsed mid-copy with different src/len: ignored, original copy completes unchanged.
- Reset asserted while in WR_REQ: data_req drops asynchronously, all outputs 0, no done_irq. A new start after reset copies correctly.
- DMA_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, responder never grants: data_req held 8 cycles then drops; err=1, done_irq=1. irq_clear clears both.
